// File: rtl/regf_pkg.sv
// Shared definitions for the I3C controller register file: well-known entry
// addresses, the reset image of the array and the burst FSM state encoding.
package regf_pkg;

    localparam int REGF_NUM_FRAMES  = 1;
    localparam int REGF_BROADCAST   = 46;
    localparam int REGF_RO_BASE     = 381;
    localparam int REGF_CAP_BCR     = 384;
    localparam int REGF_RO_LAST     = 397;
    localparam int REGF_PAYLOAD_SIZE = 400;
    localparam int REGF_ARBITRATION = 402;
    localparam int REGF_IBI_CFG     = 404;
    localparam int REGF_HJ_CFG      = 405;
    localparam int REGF_CRH_CTRL    = 406;
    localparam int REGF_CRH_STATUS  = 407;
    localparam int REGF_TGTS_COUNT  = 408;
    localparam int REGF_HJ_SUPPORT  = 409;
    localparam int REGF_ENEC        = 410;
    localparam int REGF_DISEC       = 411;
    localparam int REGF_DERIVED_BIT = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } regf_state_e;

    // Reset image; capability constants live inside the read-only window
    function automatic logic [7:0] regf_init_val(input int addr);
        logic [7:0] val;
        case (addr)
            REGF_BROADCAST:    val = 8'hFC;
            REGF_RO_BASE:      val = 8'h01;
            REGF_CAP_BCR:      val = 8'h95;
            REGF_RO_LAST:      val = 8'h3C;
            REGF_PAYLOAD_SIZE: val = 8'h10;
            REGF_CRH_CTRL:     val = 8'h00;
            REGF_CRH_STATUS:   val = 8'h00;
            REGF_TGTS_COUNT:   val = 8'h00;
            REGF_ENEC:         val = 8'h0B;
            REGF_DISEC:        val = 8'h00;
            default:           val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/regf_multiport_arb.sv
// Round-robin arbiter: grants the lowest requesting index at or after the pointer.
module regf_rr_arbiter
    import regf_pkg::*;
#(
    parameter int NPORTS = 3,
    parameter int PTRW   = 2
) (
    input  logic [NPORTS-1:0] i_req,
    input  logic [PTRW-1:0]   i_ptr,
    output logic [NPORTS-1:0] o_gnt
);

    logic [PTRW-1:0] idx_s;
    logic            found_s;

    // Scan ports starting at the pointer, first requester wins
    always_comb begin
        o_gnt   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx_s        = PTRW'((int'(i_ptr) + k) % NPORTS);
            o_gnt[idx_s] = o_gnt[idx_s] | (i_req[idx_s] & ~found_s);
            found_s      = found_s | i_req[idx_s];
        end
    end

endmodule

// File: rtl/regf_multiport.sv
// Multi-port register file for the I3C controller: round-robin burst access,
// read-only capability window, derived IBI/arbitration bits and status mirrors.
module regf_multiport
    import regf_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 1024,
    parameter int ADDR    = 10,
    parameter int NPORTS  = 3,
    parameter int LENW    = 4,
    parameter int RO_BASE = REGF_RO_BASE,
    parameter int RO_LAST = REGF_RO_LAST
) (
    input  logic                     i_regf_clk,
    input  logic                     i_regf_rst_n,
    input  logic [NPORTS-1:0]        i_port_req,
    input  logic [NPORTS-1:0]        i_port_wr,
    input  logic [NPORTS*ADDR-1:0]   i_port_addr,
    input  logic [NPORTS*LENW-1:0]   i_port_len,
    input  logic [NPORTS*WIDTH-1:0]  i_port_wdata,
    output logic [NPORTS-1:0]        o_port_gnt,
    output logic [NPORTS-1:0]        o_port_rvalid,
    output logic [WIDTH-1:0]         o_port_rdata,
    output logic [NPORTS-1:0]        o_port_done,
    output logic [NPORTS-1:0]        o_port_err,
    output logic [WIDTH-1:0]         o_regf_num_frames,
    output logic [2:0]               o_regf_hj_cfg,
    output logic                     o_regf_hj_support
);

    localparam int PTRW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    regf_state_e       state_q, state_d;
    logic [PTRW-1:0]   port_q, port_d, ptr_q, ptr_d, arb_idx_s, beat_idx_s;
    logic              wr_q, wr_d, gap_q, gap_d;
    logic [ADDR-1:0]   addr_q, addr_d, beat_addr_s;
    logic [LENW-1:0]   len_q, len_d, cnt_q, cnt_d;
    logic              beat_vld_s, beat_wr_s, beat_last_s, beat_ro_s, beat_oob_s;
    logic              mem_wr_s, derived_s;
    logic [WIDTH-1:0]  wdata_s;
    logic [NPORTS-1:0] arb_gnt_s, gnt_s, done_s, err_s, rvalid_q, rvalid_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d, num_frames_q, num_frames_d;
    logic [2:0]        hj_cfg_q, hj_cfg_d;
    logic              hj_support_q, hj_support_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] idx);
        return (idx == PTRW'(NPORTS - 1)) ? '0 : idx + PTRW'(1);
    endfunction

    function automatic logic [ADDR-1:0] next_addr(input logic [ADDR-1:0] a);
        return (a == ADDR'(DEPTH - 1)) ? '0 : a + ADDR'(1);
    endfunction

    regf_rr_arbiter #(
        .NPORTS (NPORTS),
        .PTRW   (PTRW)
    ) u_arb (
        .i_req  (i_port_req),
        .i_ptr  (ptr_q),
        .o_gnt  (arb_gnt_s)
    );

    // One-hot arbiter grant to port index
    always_comb begin
        arb_idx_s = '0;
        for (int p = 0; p < NPORTS; p++) begin
            arb_idx_s = arb_gnt_s[p] ? PTRW'(p) : arb_idx_s;
        end
    end

    // Burst FSM: the grant cycle in IDLE is beat 0, later beats come from the latched context
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        wr_d        = wr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        beat_vld_s  = 1'b0;
        beat_idx_s  = port_q;
        beat_wr_s   = wr_q;
        beat_addr_s = addr_q;
        beat_last_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!gap_q && (|i_port_req)) begin
                    beat_vld_s  = 1'b1;
                    beat_idx_s  = arb_idx_s;
                    beat_wr_s   = i_port_wr[arb_idx_s];
                    beat_addr_s = i_port_addr[arb_idx_s*ADDR +: ADDR];
                    beat_last_s = (i_port_len[arb_idx_s*LENW +: LENW] == '0);
                    port_d      = arb_idx_s;
                    wr_d        = i_port_wr[arb_idx_s];
                    len_d       = i_port_len[arb_idx_s*LENW +: LENW];
                    cnt_d       = LENW'(1);
                    state_d     = ST_BURST;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (i_port_req[port_q]) begin
                    beat_vld_s  = 1'b1;
                    beat_last_s = (cnt_q == len_q);
                    cnt_d       = cnt_q + LENW'(1);
                end else begin
                    state_d     = ST_IDLE;
                    ptr_d       = next_ptr(port_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        addr_d  = beat_vld_s ? next_addr(beat_addr_s) : addr_q;
        state_d = (beat_vld_s && beat_last_s) ? ST_IDLE : state_d;
        ptr_d   = (beat_vld_s && beat_last_s) ? next_ptr(beat_idx_s) : ptr_d;
        gap_d   = beat_vld_s & beat_last_s;
    end

    // Per-beat handshakes, write qualification and read data capture
    always_comb begin
        beat_oob_s = ({1'b0, beat_addr_s} >= (ADDR+1)'(DEPTH));
        beat_ro_s  = (beat_addr_s >= ADDR'(RO_BASE)) && (beat_addr_s <= ADDR'(RO_LAST));
        mem_wr_s   = beat_vld_s & beat_wr_s & ~beat_ro_s & ~beat_oob_s;
        wdata_s    = i_port_wdata[beat_idx_s*WIDTH +: WIDTH];
        gnt_s      = '0;
        done_s     = '0;
        err_s      = '0;
        rvalid_d   = '0;
        gnt_s[beat_idx_s]    = beat_vld_s;
        done_s[beat_idx_s]   = beat_vld_s & beat_last_s;
        err_s[beat_idx_s]    = beat_vld_s & beat_wr_s & (beat_ro_s | beat_oob_s);
        rvalid_d[beat_idx_s] = beat_vld_s & ~beat_wr_s;
        rdata_d = (beat_vld_s && !beat_wr_s) ? (beat_oob_s ? '0 : mem_q[beat_addr_s]) : rdata_q;
    end

    // Next array image: derived bits first so a same-cycle port write overrides them
    always_comb begin
        derived_s = mem_q[REGF_HJ_SUPPORT][0] & mem_q[REGF_HJ_CFG][1];
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        mem_d[REGF_ARBITRATION][REGF_DERIVED_BIT] = derived_s;
        mem_d[REGF_IBI_CFG][REGF_DERIVED_BIT]     = ~derived_s;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (mem_wr_s && (beat_addr_s == ADDR'(i))) ? wdata_s : mem_d[i];
        end
        num_frames_d = mem_q[REGF_NUM_FRAMES];
        hj_cfg_d     = mem_q[REGF_HJ_CFG][2:0];
        hj_support_d = mem_q[REGF_HJ_SUPPORT][0];
    end

    // Control state, read port and status mirror registers
    always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
        if (!i_regf_rst_n) begin
            state_q      <= ST_IDLE;
            port_q       <= '0;
            ptr_q        <= '0;
            wr_q         <= 1'b0;
            gap_q        <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
            num_frames_q <= '0;
            hj_cfg_q     <= 3'b000;
            hj_support_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            ptr_q        <= ptr_d;
            wr_q         <= wr_d;
            gap_q        <= gap_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            num_frames_q <= num_frames_d;
            hj_cfg_q     <= hj_cfg_d;
            hj_support_q <= hj_support_d;
        end
    end

    // Register array, loaded with the package reset image
    always_ff @(posedge i_regf_clk or negedge i_regf_rst_n) begin
        if (!i_regf_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(regf_init_val(i));
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign o_port_gnt        = gnt_s;
    assign o_port_done       = done_s;
    assign o_port_err        = err_s;
    assign o_port_rvalid     = rvalid_q;
    assign o_port_rdata      = rdata_q;
    assign o_regf_num_frames = num_frames_q;
    assign o_regf_hj_cfg     = hj_cfg_q;
    assign o_regf_hj_support = hj_support_q;

endmodule

// File: tb/tb_regf_multiport.sv
// Directed self-checking bench for regf_multiport.
module tb_regf_multiport;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [29:0] addr;
    logic [11:0] len;
    logic [23:0] wdata;
    logic [2:0]  o_port_gnt, o_port_rvalid, o_port_done, o_port_err;
    logic [7:0]  o_port_rdata, o_regf_num_frames;
    logic [2:0]  o_regf_hj_cfg;
    logic        o_regf_hj_support;

    int          checks;
    int          failures;
    logic [7:0]  model [1024];

    regf_multiport dut (
        .i_regf_clk        (clk),
        .i_regf_rst_n      (rst_n),
        .i_port_req        (req),
        .i_port_wr         (wr),
        .i_port_addr       (addr),
        .i_port_len        (len),
        .i_port_wdata      (wdata),
        .o_port_gnt        (o_port_gnt),
        .o_port_rvalid     (o_port_rvalid),
        .o_port_rdata      (o_port_rdata),
        .o_port_done       (o_port_done),
        .o_port_err        (o_port_err),
        .o_regf_num_frames (o_regf_num_frames),
        .o_regf_hj_cfg     (o_regf_hj_cfg),
        .o_regf_hj_support (o_regf_hj_support)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_ro(input int a);
        return (a >= 381) && (a <= 397);
    endfunction

    // Runs one burst on port p; keep < l+1 drops the request after 'keep' beats.
    // Entered and left at 1 time unit after a rising edge with the FSM free to grant.
    task automatic burst(input int p, input bit w, input int a, input int l,
                         input logic [7:0] base, input int keep);
        int         ad;
        logic [7:0] exp_rd;
        logic [2:0] oh;
        oh = 3'(1 << p);
        ad = a;
        req[p]             = 1'b1;
        wr[p]              = w;
        addr[p*10 +: 10]   = 10'(a);
        len[p*4 +: 4]      = 4'(l);
        for (int b = 0; b < keep; b++) begin
            wdata[p*8 +: 8] = base + 8'(b);
            #1;
            chk_eq("gnt", 32'(o_port_gnt), 32'(oh));
            chk_eq("done", 32'(o_port_done), (b == l) ? 32'(oh) : 32'd0);
            chk_eq("err", 32'(o_port_err), (w && is_ro(ad)) ? 32'(oh) : 32'd0);
            exp_rd = model[ad];
            if (w && !is_ro(ad)) model[ad] = base + 8'(b);
            @(posedge clk); #1;
            chk_eq("rvalid", 32'(o_port_rvalid), w ? 32'd0 : 32'(oh));
            if (!w) chk_eq("rdata", 32'(o_port_rdata), 32'(exp_rd));
            ad = (ad + 1) % 1024;
        end
        req[p] = 1'b0;
        #1;
        chk_eq("idle_gnt", 32'(o_port_gnt), 32'd0);
        chk_eq("idle_done", 32'(o_port_done), 32'd0);
        @(posedge clk); #1;
        chk_eq("idle_rvalid", 32'(o_port_rvalid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 1024; i++) model[i] = 8'h00;
        model[46] = 8'hFC; model[381] = 8'h01; model[384] = 8'h95; model[397] = 8'h3C;
        model[400] = 8'h10; model[410] = 8'h0B; model[404] = 8'h08;
        rst_n = 1'b0; req = '0; wr = '0; addr = '0; len = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_gnt", 32'(o_port_gnt), 32'd0);
        chk_eq("rst_rvalid", 32'(o_port_rvalid), 32'd0);
        chk_eq("rst_rdata", 32'(o_port_rdata), 32'd0);
        chk_eq("rst_done", 32'(o_port_done), 32'd0);
        chk_eq("rst_err", 32'(o_port_err), 32'd0);
        chk_eq("rst_num_frames", 32'(o_regf_num_frames), 32'd0);
        chk_eq("rst_hj_cfg", 32'(o_regf_hj_cfg), 32'd0);
        chk_eq("rst_hj_support", 32'(o_regf_hj_support), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset image read, then rdata must hold
        burst(0, 1'b0, 46, 0, 8'h00, 1);
        chk_eq("rdata_hold", 32'(o_port_rdata), 32'h0000_00FC);

        // Wrapping write burst and read-back
        burst(1, 1'b1, 1022, 3, 8'hA0, 4);
        burst(1, 1'b0, 1022, 3, 8'h00, 4);
        chk_eq("num_frames", 32'(o_regf_num_frames), 32'h0000_00A3);

        // Read-only window write is discarded with err
        burst(2, 1'b1, 384, 0, 8'h55, 1);
        burst(2, 1'b0, 384, 0, 8'h00, 1);
        chk_eq("ro_kept", 32'(o_port_rdata), 32'h0000_0095);
        burst(2, 1'b0, 404, 0, 8'h00, 1);

        // Three simultaneous requests, pointer at port 0
        req = 3'b111; wr = 3'b000; len = '0;
        addr = {10'd384, 10'd1023, 10'd46};
        #1;
        chk_eq("rr_gnt0", 32'(o_port_gnt), 32'd1);
        chk_eq("rr_done0", 32'(o_port_done), 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        chk_eq("rr_rvalid0", 32'(o_port_rvalid), 32'd1);
        chk_eq("rr_rdata0", 32'(o_port_rdata), 32'h0000_00FC);
        #1;
        chk_eq("rr_gap0", 32'(o_port_gnt), 32'd0);
        @(posedge clk); #1; #1;
        chk_eq("rr_gnt1", 32'(o_port_gnt), 32'd2);
        @(posedge clk); #1;
        req[1] = 1'b0;
        chk_eq("rr_rvalid1", 32'(o_port_rvalid), 32'd2);
        chk_eq("rr_rdata1", 32'(o_port_rdata), 32'h0000_00A1);
        #1;
        chk_eq("rr_gap1", 32'(o_port_gnt), 32'd0);
        @(posedge clk); #1; #1;
        chk_eq("rr_gnt2", 32'(o_port_gnt), 32'd4);
        @(posedge clk); #1;
        req[2] = 1'b0;
        chk_eq("rr_rvalid2", 32'(o_port_rvalid), 32'd4);
        chk_eq("rr_rdata2", 32'(o_port_rdata), 32'h0000_0095);
        @(posedge clk); #1;

        // Hot-join configuration drives the derived bits and mirrors
        burst(0, 1'b1, 409, 0, 8'h01, 1);
        burst(1, 1'b1, 405, 0, 8'h02, 1);
        chk_eq("hj_support", 32'(o_regf_hj_support), 32'd1);
        chk_eq("hj_cfg", 32'(o_regf_hj_cfg), 32'd2);
        burst(2, 1'b1, 10, 2, 8'h30, 3);
        model[402] = 8'h08;
        model[404] = 8'h00;
        burst(0, 1'b0, 402, 0, 8'h00, 1);
        burst(1, 1'b0, 404, 0, 8'h00, 1);

        // Port 0 abandons a read burst after 3 beats while port 1 waits
        req[1] = 1'b1; wr[1] = 1'b0; addr[10 +: 10] = 10'd46; len[4 +: 4] = 4'd0;
        burst(0, 1'b0, 10, 7, 8'h00, 3);
        chk_eq("drop_next_gnt", 32'(o_port_gnt), 32'd2);
        chk_eq("drop_next_done", 32'(o_port_done), 32'd2);
        @(posedge clk); #1;
        req[1] = 1'b0;
        chk_eq("drop_next_rvalid", 32'(o_port_rvalid), 32'd2);
        chk_eq("drop_next_rdata", 32'(o_port_rdata), 32'h0000_00FC);
        @(posedge clk); #1;

        // Write burst straddling the end of the read-only window
        burst(0, 1'b1, 396, 2, 8'hC0, 3);
        burst(0, 1'b0, 396, 2, 8'h00, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
